// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle: empty flag, show-ahead head word, pop strobe.
// master = FIFO side, slave = consumer side.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd;

  modport master (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd
  );

  modport slave (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame, sends start/data/stop.
// Optional even parity bit when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  fifo_uart_tx_if.slave fifo,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CPRE = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IMAX = IW'(WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sh_nx;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign fifo.fifo_rd = (state_q == S_IDLE) && enable
                        && !fifo.fifo_empty;
  assign last  = (cnt_q == CMAX);
  assign sh_nx = sh_q >> 1;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;

  // Next-state logic: frame sequencing, baud count, shift and outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (fifo.fifo_rd) begin
          sh_d    = fifo.fifo_rdata;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
`ifdef FIFO_UART_TX_PARITY_EN
          par_d   = ^fifo.fifo_rdata;
`endif
        end
      end
      S_START: begin
        if (last) begin
          tx_d    = sh_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last) begin
          if (idx_q == IMAX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            sh_d  = sh_nx;
            idx_d = idx_q + IW'(1);
            tx_d  = sh_nx[0];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (last) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CPRE) done_d = 1'b1;
        if (last) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: FIFO model feeds words, a line
// monitor decodes tx frames and compares them with the expected queue.
module tb_fifo_uart_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int F = NB * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic tx, busy, done;

  fifo_uart_tx_if #(.WIDTH(W)) fif ();

  fifo_uart_tx #(
    .WIDTH(W),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .enable(enable),
    .fifo(fif),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int pushed = 0;
  logic rd_s = 1'b0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int starts[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic void refresh();
    fif.fifo_empty = (fq.size() == 0);
    fif.fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    pushed++;
    refresh();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: pop strobe sampled mid-cycle, head advances after the edge.
  always @(negedge clk) rd_s = fif.fifo_rd && rst_n;
  always @(posedge clk) begin
    #1;
    if (rd_s) begin
      if (fq.size() != 0) void'(fq.pop_front());
      pop_cnt++;
      rd_s = 1'b0;
    end
    refresh();
  end

  // Pop gating: never when empty, never while enable is low.
  always @(negedge clk) begin
    if (fif.fifo_empty || !enable)
      chk("rd_gate", {31'b0, fif.fifo_rd}, 0);
  end

  task automatic frame();
    logic [NB-1:0] bits;
    logic [W-1:0] w;
    bit ab;
    bits = '0;
    ab = 0;
    starts.push_back(cyc);
    for (int k = 0; k < F; k++) begin
      if (k > 0) @(negedge clk);
      if (!rst_n) begin
        ab = 1;
        break;
      end
      chk("busy_in_frame", {31'b0, busy}, 1);
      chk("done_pos", {31'b0, done}, {31'b0, (k == F - 1)});
      if (k % C == C / 2) bits[k / C] = tx;
    end
    if (ab) return;
    chk("start_bit", {31'b0, bits[0]}, 0);
    chk("stop_bit", {31'b0, bits[NB-1]}, 1);
    chk("frame_expected", {31'b0, exp_q.size() != 0}, 1);
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("data", {24'b0, bits[W:1]}, {24'b0, w});
`ifdef FIFO_UART_TX_PARITY_EN
      chk("parity", {31'b0, bits[W+1]}, $countones(w) % 2);
`endif
    end
    @(negedge clk);
    if (rst_n) begin
      chk("gap_busy", {31'b0, busy}, 0);
      chk("gap_tx", {31'b0, tx}, 1);
      chk("gap_done", {31'b0, done}, 0);
    end
  endtask

  // Line monitor: decode frames, otherwise check quiet idle outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) frame();
      else begin
        chk("idle_busy", {31'b0, busy}, 0);
        chk("idle_done", {31'b0, done}, 0);
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", {31'b0, n < budget}, 1);
    tick(3);
  endtask

  task automatic wait_start(input int s0);
    int n;
    n = 0;
    while (starts.size() == s0 && n < 100) begin
      tick(1);
      n++;
    end
    chk("start_timeout", {31'b0, n < 100}, 1);
  endtask

  initial begin
    int p0, s0;
    refresh();
    tick(5);
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    tick(50);
    chk("idle_tx", {31'b0, tx}, 1);
    chk("idle_pops", pop_cnt, 0);

    p0 = pop_cnt;
    push(8'h7E);
    drain(200);
    chk("single_pops", pop_cnt - p0, 1);

    p0 = pop_cnt;
    s0 = starts.size();
    push(8'h7E);
    push(8'h2A);
    drain(300);
    chk("b2b_pops", pop_cnt - p0, 2);
    if (starts.size() >= s0 + 2)
      chk("b2b_spacing", starts[s0+1] - starts[s0], F + 1);
    else
      chk("b2b_frames", starts.size() - s0, 2);

    enable = 1'b0;
    p0 = pop_cnt;
    push(8'h55);
    tick(20);
    chk("en_off_pops", pop_cnt - p0, 0);
    chk("en_off_tx", {31'b0, tx}, 1);
    s0 = starts.size();
    enable = 1'b1;
    wait_start(s0);
    tick(10);
    enable = 1'b0;
    push(8'h33);
    tick(F + 20);
    chk("en_mid_pops", pop_cnt - p0, 1);
    chk("en_mid_left", exp_q.size(), 1);
    enable = 1'b1;
    drain(200);

    s0 = starts.size();
    push(8'h2A);
    push(8'h99);
    wait_start(s0);
    tick(14);
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", {31'b0, tx}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    tick(3);
    rst_n = 1'b1;
    tick(2);
    enable = 1'b1;
    drain(200);

    for (int i = 0; i < 20; i++) begin
      push(W'($urandom));
      enable = ($urandom_range(0, 3) != 0);
      tick($urandom_range(0, 60));
    end
    enable = 1'b1;
    drain(3000);

    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_fifo_empty", fq.size(), 0);
    chk("end_pop_count", pop_cnt, pushed);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's FIFO buffer. Pops words from the FIFO's read/empty/data interface and sends each one as an asynchronous serial frame on a single `tx` line.
- Frame format: 1 start bit, WIDTH data bits LSB first, optional parity bit, 1 stop bit.
- Sits between a FIFO instance and an off-chip UART pin. The FIFO absorbs bursts and this block paces them out at the bit rate.

Parameters:
- WIDTH, 8, data word width; matches the FIFO width.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  when 1, permits starting a new frame.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  WIDTH  FIFO head word; show-ahead, valid whenever fifo_empty=0.
- fifo_rd  output  1  FIFO pop strobe, one cycle per word.
- tx  output  1  serial line; idles high.
- busy  output  1  1 while a frame is in progress (START, DATA, PARITY or STOP).
- done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, busy=0, done=0.
  - Baud counter=0, bit index=0, shift register=0.
  - fifo_rd=0.
- Output types:
  - tx, busy and done are registered.
  - fifo_rd is combinational: fifo_rd = (state==IDLE) && enable && !fifo_empty.
- States: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP.
- IDLE:
  - tx=1.
  - When fifo_rd=1, fifo_rdata loads into the shift register on the same edge the FIFO pops. Next state is START.
  - Otherwise remain in IDLE.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - tx goes low at the same edge that ends the fifo_rd cycle.
  - Latency from pop to start-bit edge: 0 cycles after the pop edge.
- DATA:
  - tx = shift register bit 0, held for CLKS_PER_BIT cycles per bit.
  - After each bit, shift right and increment the bit index.
  - After bit WIDTH-1, go to PARITY if enabled, else STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - done=1 during the final stop cycle only.
  - Then IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and resets to 0 on every state/bit boundary.
  - Bit index width is $clog2(WIDTH), minimum 1.
- Frame length: F = (WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
- Back-to-back frames:
  - At least one IDLE cycle between frames.
  - Start-to-start spacing with a non-empty FIFO is F+1 cycles.
- enable=0:
  - Blocks only new frames. A frame in progress always completes.
- fifo_empty=1 in IDLE: no pop, tx stays 1, busy=0.
- fifo_rdata is ignored outside the IDLE pop cycle. FIFO writes during a frame have no effect on the frame in progress.
- Reset mid-frame:
  - tx returns to 1 immediately and the frame is aborted.
  - The popped word is lost and is not re-read.
- The block never asserts fifo_rd while fifo_empty=1, so underflow is impossible.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - tx = XOR of all WIDTH data bits (even parity), computed from the word captured at pop.
  - Held for CLKS_PER_BIT cycles. Frame length (WIDTH+3)*CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic. Frame length (WIDTH+2)*CLKS_PER_BIT.

Test Plan (WIDTH=8, CLKS_PER_BIT=4 unless noted):
- Reset held, then released with fifo_empty=1 and enable=1 for 50 cycles -> tx=1, fifo_rd=0, busy=0, done=0 throughout.
- Single word 0x7E, fifo_empty 1→0, enable=1 -> fifo_rd high for exactly 1 cycle.
  - tx sampled mid-bit reads 0 | 0,1,1,1,1,1,1,0 | 1.
  - busy high for 40 cycles; done pulses once on cycle 40.
- Two words 0x7E then 0x2A queued -> two frames with start edges exactly 41 cycles apart.
  - Second data bits: 0,1,0,1,0,1,0,0.
  - Exactly 2 fifo_rd pulses.
- enable=0 with fifo_empty=0 for 20 cycles -> no fifo_rd, tx=1.
  - Deassert enable 10 cycles into a frame -> frame completes normally, no further pop.
- Reset pulled low 15 cycles into a 0x2A frame -> tx=1 and busy=0 asynchronously.
  - After release, next pop sends the following FIFO word, not 0x2A.
- With FIFO_UART_TX_PARITY_EN: 0x2A (three 1s) -> parity bit 1; 0x7E (six 1s) -> parity bit 0.
  - Frame 44 cycles; done on cycle 44.
